mult_div_unit: RTL



---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mdu_iter_core.sv | 85 ++++++++
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and sizing constants for mult_div_unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = MDU_WIDTH;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/result bundle between pipeline and mult_div_unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic             unsupported;
  logic [WIDTH-1:0] hiOut;
  logic [WIDTH-1:0] loOut;

  modport master (
    output start, op, srcA, srcB, mthi, mtlo, writeData,
    input  busy, done, unsupported, hiOut, loOut
  );

  modport slave (
    input  start, op, srcA, srcB, mthi, mtlo, writeData,
    output busy, done, unsupported, hiOut, loOut
  );

endinterface

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - accumulator, iteration counter and radix-2 step (divide path under MDU_DIV_EN)
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  // a_q is consumed MSB-first: multiplier bits for multiply, dividend bits for divide
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;

  assign mul_next = (acc_q << 1) + (a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0);

`ifdef MDU_DIV_EN
  // acc holds {partial remainder, quotient bits shifted in from the right}
  logic [WIDTH:0]     part_rem;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;

  assign part_rem = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign trial    = part_rem - {1'b0, b_q};
  assign div_next = (part_rem >= {1'b0, b_q})
                  ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                  : {part_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign step_next = is_div_i ? div_next : mul_next;
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
  assign step_next     = mul_next;
`endif

  // load clears the accumulator and arms the counter; step advances one radix-2 iteration
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = CW'(ITERS - 1);
    end else if (step_i) begin
      a_d   = a_q << 1;
      acc_d = step_next;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // iteration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO; divider built only with MDU_DIV_EN
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITERS = WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);

  state_e             state_q, state_d;
  op_e                op_in;
  op_e                op_q;
  logic               signed_op, sign_a, sign_b;
  logic               sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               start_ok, accept;
  logic [2*WIDTH-1:0] core_acc;
  logic               core_last;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign op_in     = op_e'(bus.op);
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign sign_a    = signed_op & bus.srcA[WIDTH-1];
  assign sign_b    = signed_op & bus.srcB[WIDTH-1];

`ifdef MDU_DIV_EN
  logic             divzero_q;
  logic [WIDTH-1:0] quo, rem;
  assign start_ok        = 1'b1;
  assign quo             = core_acc[WIDTH-1:0];
  assign rem             = core_acc[2*WIDTH-1:WIDTH];
  assign bus.unsupported = 1'b0;
`else
  logic unsup_q;
  assign start_ok        = !is_div_op(op_in);
  assign bus.unsupported = unsup_q;
`endif

  assign accept = (state_q == IDLE) && bus.start && start_ok;

  // next-state logic; PREP and RUN drive the iteration core directly from the state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PREP;
      PREP:    state_d = RUN;
      RUN:     if (core_last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // capture op, signs and magnitudes at the accepting edge so later operand changes are harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      sign_a_q <= sign_a;
      sign_b_q <= sign_b;
      mag_a_q  <= sign_a ? -bus.srcA : bus.srcA;
      mag_b_q  <= sign_b ? -bus.srcB : bus.srcB;
    end
  end

`ifdef MDU_DIV_EN
  // a zero divisor overrides the quotient with all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      divzero_q <= 1'b0;
    else if (accept) divzero_q <= (bus.srcB == '0);
  end
`else
  // rejected divide starts report a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unsup_q <= 1'b0;
    else        unsup_q <= (state_q == IDLE) && bus.start && is_div_op(op_in);
  end
`endif

  mdu_iter_core #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (state_q == PREP),
    .step_i   (state_q == RUN),
    .is_div_i (is_div_op(op_q)),
    .a_i      (mag_a_q),
    .b_i      (mag_b_q),
    .acc_o    (core_acc),
    .last_o   (core_last)
  );

  assign prod_s = (sign_a_q ^ sign_b_q) ? -core_acc : core_acc;

  // sign correction of the magnitude result into HI/LO form
  always_comb begin
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div_op(op_q)) begin
      // with a zero divisor the sign-corrected remainder is srcA itself
      res_lo = divzero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quo : quo);
      res_hi = sign_a_q ? -rem : rem;
    end
`endif
  end

  // HI/LO: FIX result wins; mthi/mtlo only when idle and no start is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == FIX) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if ((state_q == IDLE) && !bus.start) begin
      if (bus.mthi) hi_q <= bus.writeData;
      if (bus.mtlo) lo_q <= bus.writeData;
    end
  end

  // done pulses in the cycle after FIX, alongside the new HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_q == FIX);
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.hiOut = hi_q;
  assign bus.loOut = lo_q;

endmodule
